// File: rtl/q_argmax_seq.sv
// Sequential max/argmax over N masked Q-values, one entry per clock.
// Inputs are snapshotted on start; results are registered and held until the next done.
module q_argmax_seq #(
    parameter int N = 9,
    parameter int W = 16,
    parameter bit SIGNED = 1'b1,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*W-1:0]   q_vec,
    input  logic [N-1:0]     legal_mask,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     max_q,
    output logic [IDX_W-1:0] max_idx,
    output logic             none_legal
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q;
    logic [W-1:0]     qSnap_q [N];
    logic [N-1:0]     mask_q;
    logic [IDX_W-1:0] scanIdx_q;
    logic [W-1:0]     best_q;
    logic [IDX_W-1:0] bestIdx_q;
    logic             found_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     maxQ_q;
    logic [IDX_W-1:0] maxIdx_q;
    logic             noneLegal_q;

    logic [W-1:0]     curVal;
    logic             curBetter;
    logic             takeEntry;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        curVal = qSnap_q[scanIdx_q];
        if (SIGNED) begin
            curBetter = $signed(curVal) > $signed(best_q);
        end else begin
            curBetter = curVal > best_q;
        end
        takeEntry = mask_q[scanIdx_q] && (!found_q || curBetter);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < N; i++) begin
                qSnap_q[i] <= '0;
            end
            mask_q      <= '0;
            scanIdx_q   <= '0;
            best_q      <= '0;
            bestIdx_q   <= '0;
            found_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            maxQ_q      <= '0;
            maxIdx_q    <= '0;
            noneLegal_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            qSnap_q[i] <= q_vec[i*W +: W];
                        end
                        mask_q    <= legal_mask;
                        scanIdx_q <= '0;
                        best_q    <= '0;
                        bestIdx_q <= '0;
                        found_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (takeEntry) begin
                        best_q    <= curVal;
                        bestIdx_q <= scanIdx_q;
                        found_q   <= 1'b1;
                    end
                    if (scanIdx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        scanIdx_q <= scanIdx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    // best_q/bestIdx_q stay zero when nothing was legal.
                    maxQ_q      <= best_q;
                    maxIdx_q    <= bestIdx_q;
                    noneLegal_q <= !found_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign max_q      = maxQ_q;
    assign max_idx    = maxIdx_q;
    assign none_legal = noneLegal_q;

endmodule
